// File: rtl/dequantizer_if.sv
// Handshake bundle for the block dequantizer.
//   data_in / max_num / data_in_valid / data_in_ready : one input block of signed
//     codes plus its unsigned absolute-max, valid/ready handshake.
//   data_out / data_out_valid / data_out_ready        : dequantized block, valid/ready.
// Modports: master = block producer/consumer side (testbench), slave = dequantizer.
interface dequantizer_if #(
  parameter int IN_WIDTH       = 8,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int MAX_NUM_WIDTH  = 16,
  parameter int OUT_WIDTH      = 16
);
  localparam int N = IN_SIZE * IN_PARALLELISM;

  logic signed [IN_WIDTH-1:0]  data_in [N-1:0];
  logic        [MAX_NUM_WIDTH-1:0] max_num;
  logic                        data_in_valid;
  logic                        data_in_ready;
  logic signed [OUT_WIDTH-1:0] data_out [N-1:0];
  logic                        data_out_valid;
  logic                        data_out_ready;

  modport master (
    output data_in, max_num, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in, max_num, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/dequantizer.sv
// Block dequantizer: data_out[i] = round(q[i] * max_num / QMAX), QMAX = 2^(IN_WIDTH-1)-1.
// The per-block step max_num/QMAX (STEP_FRAC_WIDTH fractional bits) comes from a
// bit-serial restoring divider and is cached against max_num, so a block whose
// max_num matches the previous one skips the divide.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - dequantizer_if.slave: data_in/max_num/valid/ready in, data_out/valid/ready out
module dequantizer #(
  parameter int IN_WIDTH        = 8,
  parameter int IN_SIZE         = 4,
  parameter int IN_PARALLELISM  = 1,
  parameter int MAX_NUM_WIDTH   = 16,
  parameter int STEP_FRAC_WIDTH = 16,
  parameter int OUT_WIDTH       = 16,
  parameter int OUT_FRAC_WIDTH  = 0
) (
  input  logic           clk,
  input  logic           rst,
  dequantizer_if.slave   bus
);
  localparam int N  = IN_SIZE * IN_PARALLELISM;
  localparam int D  = MAX_NUM_WIDTH + STEP_FRAC_WIDTH;
  localparam int CW = $clog2(D + 1);
  localparam int PW = IN_WIDTH + MAX_NUM_WIDTH + STEP_FRAC_WIDTH + 1;
  localparam int S  = STEP_FRAC_WIDTH - OUT_FRAC_WIDTH;
  localparam int SH = (S > 0) ? S - 1 : 0;

  localparam logic [IN_WIDTH-1:0] QMAX = {1'b0, {(IN_WIDTH-1){1'b1}}};
  localparam logic signed [PW:0]  HALF = (S > 0) ? ((PW+1)'(1) << SH) : '0;
  localparam logic signed [PW:0]  OMAX = {{(PW+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [PW:0]  OMIN = {{(PW+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  // Round to nearest (ties toward +inf) while dropping S fractional bits.
  function automatic logic signed [PW:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW:0] x;
    x = {p[PW-1], p} + HALF;
    return x >>> S;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [PW:0] x);
    if (x > OMAX)      return OMAX[OUT_WIDTH-1:0];
    else if (x < OMIN) return OMIN[OUT_WIDTH-1:0];
    else               return x[OUT_WIDTH-1:0];
  endfunction

  logic [1:0]                   state;
  logic [CW-1:0]                cnt;
  logic                         cache_valid;
  logic [MAX_NUM_WIDTH-1:0]     cache_max;
  logic [D-1:0]                 step;
  logic signed [OUT_WIDTH-1:0]  out_reg [N-1:0];

  logic signed [IN_WIDTH-1:0]   q_reg [N-1:0];
  logic [MAX_NUM_WIDTH-1:0]     max_reg;
  logic [D-1:0]                 dividend;
  logic [IN_WIDTH-2:0]          rem;
  logic [D-2:0]                 quot;

  logic                         accept;
  logic [IN_WIDTH-1:0]          rem_sh;
  logic                         q_bit;
  logic [IN_WIDTH-2:0]          rem_nx;
  logic signed [OUT_WIDTH-1:0]  mul_res [N-1:0];

  // Ready is forced low while reset is held, not just by the IDLE state.
  assign bus.data_in_ready  = (state == IDLE) && rst;
  assign bus.data_out_valid = (state == OUT);
  assign bus.data_out       = out_reg;
  assign accept             = bus.data_in_valid && bus.data_in_ready;

  // Divider iteration: the remainder stays below QMAX, so it fits IN_WIDTH-1 bits.
  always_comb begin
    rem_sh = {rem, dividend[D-1]};
    q_bit  = (rem_sh >= QMAX);
    rem_nx = q_bit ? (IN_WIDTH-1)'(rem_sh - QMAX) : rem_sh[IN_WIDTH-2:0];
  end

  always_comb begin
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    b = PW'($signed({1'b0, step}));
    for (int i = 0; i < N; i++) begin
      a          = PW'(q_reg[i]);
      mul_res[i] = saturate(round_shift(a * b));
    end
  end

  // Stage boundary: control, step cache and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cache_valid <= 1'b0;
      cache_max   <= '0;
      step        <= '0;
      for (int i = 0; i < N; i++) out_reg[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= '0;
            state <= (cache_valid && bus.max_num == cache_max) ? MUL : DIV;
          end
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(D - 1)) begin
            step        <= {quot, q_bit};
            cache_max   <= max_reg;
            cache_valid <= 1'b1;
            state       <= MUL;
          end
        end
        MUL: begin
          for (int i = 0; i < N; i++) out_reg[i] <= mul_res[i];
          state <= OUT;
        end
        default: begin
          if (bus.data_out_ready) state <= IDLE;
        end
      endcase
    end
  end

  // Stage boundary: captured block and divider datapath (no reset needed).
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      q_reg    <= bus.data_in;
      max_reg  <= bus.max_num;
      dividend <= {bus.max_num, {STEP_FRAC_WIDTH{1'b0}}};
      rem      <= '0;
      quot     <= '0;
    end else if (state == DIV) begin
      dividend <= dividend << 1;
      rem      <= rem_nx;
      quot     <= {quot[D-3:0], q_bit};
    end
  end
endmodule

// File: tb/tb_dequantizer.sv
module tb_dequantizer;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  dequantizer_if #(.IN_WIDTH(8), .IN_SIZE(4), .IN_PARALLELISM(1),
                   .MAX_NUM_WIDTH(16), .OUT_WIDTH(16)) bus ();

  dequantizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e0, input int e1, input int e2, input int e3);
    int ev[4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_o%0d", tag, i), bus.data_out[i], ev[i]);
  endtask

  // Handshake one block, then wait (bounded) for data_out_valid. Latency is the
  // number of rising edges from the handshake edge up to the one that raises valid.
  task automatic run_block(input string tag, input int mx,
                           input int q0, input int q1, input int q2, input int q3,
                           input int e0, input int e1, input int e2, input int e3,
                           input int lat);
    int cyc;
    @(negedge clk);
    chk({tag, "_in_rdy"}, bus.data_in_ready, 1);
    bus.max_num    = 16'(mx);
    bus.data_in[0] = 8'(q0);
    bus.data_in[1] = 8'(q1);
    bus.data_in[2] = 8'(q2);
    bus.data_in[3] = 8'(q3);
    bus.data_in_valid = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    bus.data_in_valid = 1'b0;
    while (!bus.data_out_valid && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, cyc, lat);
    chk_out(tag, e0, e1, e2, e3);
  endtask

  task automatic drain(input string tag);
    bus.data_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld_drop"}, bus.data_out_valid, 0);
    chk({tag, "_idle_rdy"}, bus.data_in_ready, 1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.data_in_valid  = 1'b0;
    bus.data_out_ready = 1'b1;
    bus.max_num        = '0;
    for (int i = 0; i < 4; i++) bus.data_in[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", bus.data_in_ready, 0);
    chk("rst_out_vld", bus.data_out_valid, 0);
    chk_out("rst", 0, 0, 0, 0);
    rst = 1'b1;

    run_block("miss127", 127, 127, -127, 1, 0, 127, -127, 1, 0, 34);
    drain("miss127");
    run_block("hit127", 127, -128, 64, 2, -1, -128, 64, 2, -1, 2);
    drain("hit127");
    run_block("miss100", 100, 127, -64, 0, 1, 100, -50, 0, 1, 34);
    drain("miss100");
    run_block("zero", 0, 5, -5, 127, -128, 0, 0, 0, 0, 34);
    drain("zero");
    run_block("sat", 65535, 127, -127, -128, 0, 32767, -32768, -32768, 0, 34);
    drain("sat");

    // Back-pressure: output must hold while ready is low.
    bus.data_out_ready = 1'b0;
    run_block("hold", 65535, 1, -1, 100, -100, 516, -516, 32767, -32768, 2);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold_vld%0d", k), bus.data_out_valid, 1);
      chk($sformatf("hold_in_rdy%0d", k), bus.data_in_ready, 0);
      chk($sformatf("hold_o0_%0d", k), bus.data_out[0], 516);
      chk($sformatf("hold_o3_%0d", k), bus.data_out[3], -32768);
    end
    drain("hold");
    chk_out("hold_kept", 516, -516, 32767, -32768);

    // Abort a miss mid-divide with an asynchronous reset.
    @(negedge clk);
    bus.max_num    = 16'd100;
    bus.data_in[0] = 8'sd1;
    bus.data_in[1] = 8'sd2;
    bus.data_in[2] = 8'sd3;
    bus.data_in[3] = 8'sd4;
    bus.data_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.data_in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_vld", bus.data_out_valid, 0);
    chk("abort_in_rdy", bus.data_in_ready, 0);
    chk_out("abort", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Cache was valid for 65535 before the reset; it must now miss.
    run_block("post_rst", 65535, 127, -127, -128, 0, 32767, -32768, -32768, 0, 34);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
